// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter placing N cache-side requesters onto one shared single-port
// memory array with a fixed access latency and a one-cycle ready pulse per access.
module mem_port_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_PORTS-1:0]                port_req,
    input  logic [N_PORTS-1:0]                port_we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]     port_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]     port_wdata,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]   port_be,
    output logic [N_PORTS-1:0]                port_ready,
    output logic [DATA_WIDTH-1:0]             port_rdata,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_be,
    output logic                              mem_we,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              busy,
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] grant_id
);
    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r;
    logic [GW-1:0]           rr_r, grant_r, win_s;
    logic                    hit_s, last_s, lat_we_r, win_we_s;
    logic [ADDR_WIDTH-1:0]   lat_addr_r, win_addr_s;
    logic [DATA_WIDTH-1:0]   lat_wdata_r, win_wdata_s, rdata_r;
    logic [BW-1:0]           lat_be_r, win_be_s;
    logic [N_PORTS-1:0]      cand_s, ready_r, ready_s;

    assign last_s     = (state_r == BUSY) && (cnt_r == LAST_CNT);
    assign busy       = (state_r == BUSY);
    assign mem_addr   = busy ? lat_addr_r  : '0;
    assign mem_wdata  = busy ? lat_wdata_r : '0;
    assign mem_be     = busy ? lat_be_r    : '0;
    assign mem_we     = last_s & lat_we_r;
    assign port_ready = ready_r;
    assign port_rdata = rdata_r;
    assign grant_id   = grant_r;

    // Round-robin search from rr+1, masking the port being completed in DONE.
    always_comb begin
        logic m;
        m           = 1'b0;
        hit_s       = 1'b0;
        win_s       = '0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        win_be_s    = '0;
        win_we_s    = 1'b0;
        ready_s     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand_s[i]  = port_req[i] & ~((state_r == DONE) && (int'(grant_r) == i));
            ready_s[i] = last_s && (int'(grant_r) == i);
        end
        for (int k = 1; k <= N_PORTS; k++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                m     = !hit_s && cand_s[i] && (i == ((int'(rr_r) + k) % N_PORTS));
                win_s = m ? GW'(i) : win_s;
                hit_s = hit_s | m;
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            m           = (int'(win_s) == i);
            win_addr_s  = m ? port_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  : win_addr_s;
            win_wdata_s = m ? port_wdata[i*DATA_WIDTH +: DATA_WIDTH] : win_wdata_s;
            win_be_s    = m ? port_be[i*BW +: BW]                    : win_be_s;
            win_we_s    = m ? port_we[i]                             : win_we_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hit_s) state_s = BUSY;
                else       state_s = IDLE;
            end
            BUSY: begin
                if (last_s) state_s = DONE;
                else        state_s = BUSY;
            end
            DONE: begin
                if (hit_s) state_s = BUSY;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Grant capture, latency counter, completion pulse and read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            rr_r        <= GW'(N_PORTS - 1);
            grant_r     <= '0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
            lat_be_r    <= '0;
            lat_we_r    <= 1'b0;
            ready_r     <= '0;
            rdata_r     <= '0;
        end else begin
            ready_r <= ready_s;
            if ((state_r != BUSY) && hit_s) begin
                lat_addr_r  <= win_addr_s;
                lat_wdata_r <= win_wdata_s;
                lat_be_r    <= win_be_s;
                lat_we_r    <= win_we_s;
                grant_r     <= win_s;
                rr_r        <= win_s;
                cnt_r       <= '0;
            end else if (last_s) begin
                cnt_r <= '0;
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (last_s) rdata_r <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 3-port/latency-2 arbiter over a byte-writable array model,
// plus a 1-port/latency-5 arbiter over an address-pattern memory.
module tb_mem_port_arbiter;
    logic clk, rst;
    int   checks, errors;

    // Instance A: N_PORTS=3, LATENCY=2
    logic [2:0]   a_req, a_we, a_ready;
    logic [95:0]  a_addr, a_wdata;
    logic [11:0]  a_be;
    logic [31:0]  a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]   a_mem_be;
    logic         a_mem_we, a_busy;
    logic [1:0]   a_gid;
    logic [31:0]  mema [0:255];
    int           a_wr_cnt;
    logic         tb_wr;
    logic [7:0]   tb_idx;
    logic [31:0]  tb_dat;

    // Instance B: N_PORTS=1, LATENCY=5
    logic [0:0]   b_req, b_we, b_ready, b_gid;
    logic [31:0]  b_addr, b_wdata, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]   b_be, b_mem_be;
    logic         b_mem_we, b_busy;

    mem_port_arbiter #(.N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .port_req(a_req), .port_we(a_we), .port_addr(a_addr),
        .port_wdata(a_wdata), .port_be(a_be), .port_ready(a_ready), .port_rdata(a_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy), .grant_id(a_gid));

    mem_port_arbiter #(.N_PORTS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(5)) u_b (
        .clk(clk), .rst(rst), .port_req(b_req), .port_we(b_we), .port_addr(b_addr),
        .port_wdata(b_wdata), .port_be(b_be), .port_ready(b_ready), .port_rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_id(b_gid));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_mem_rdata = mema[a_mem_addr[9:2]];
    assign b_mem_rdata = {b_mem_addr[15:0], 16'hC0DE};

    always @(posedge clk) begin
        if (a_mem_we) begin
            for (int b = 0; b < 4; b++)
                if (a_mem_be[b]) mema[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            a_wr_cnt <= a_wr_cnt + 1;
        end else if (tb_wr) begin
            mema[tb_idx] <= tb_dat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setp(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        a_we[p]            = we;
        a_addr[p*32 +: 32] = addr;
        a_wdata[p*32 +: 32] = wdata;
        a_be[p*4 +: 4]     = be;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [2:0] exp_r;
        checks = 0; errors = 0; a_wr_cnt = 0;
        rst = 1'b0; tb_wr = 1'b0; tb_idx = 8'd0; tb_dat = 32'd0;
        a_req = 3'b000; a_we = 3'b000; a_addr = 96'd0; a_wdata = 96'd0; a_be = 12'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_be = 4'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ready", a_ready, 3'b000);
        chk("rst_gid", a_gid, 2'd0);
        chk("rst_memwe", a_mem_we, 1'b0);
        chk("rst_memaddr", a_mem_addr, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);

        // Preload array: 0x100 -> DEADBEEF, 0x40 -> AABBCCDD
        tb_wr = 1'b1; tb_idx = 8'd64; tb_dat = 32'hDEADBEEF;
        tick();
        tb_idx = 8'd16; tb_dat = 32'hAABBCCDD;
        tick();
        tb_wr = 1'b0;
        rst = 1'b0;

        // Single read by port 0
        setp(0, 1'b0, 32'h100, 32'd0, 4'hF);
        a_req = 3'b001;
        tick();
        chk("rd_busy0", a_busy, 1'b1);
        chk("rd_memaddr", a_mem_addr, 32'h100);
        chk("rd_gid", a_gid, 2'd0);
        chk("rd_noready0", a_ready, 3'b000);
        tick();
        chk("rd_busy1", a_busy, 1'b1);
        chk("rd_nowe", a_mem_we, 1'b0);
        tick();
        chk("rd_ready", a_ready, 3'b001);
        chk("rd_busy_done", a_busy, 1'b0);
        chk("rd_data", a_rdata, 32'hDEADBEEF);
        a_req = 3'b000;
        tick();
        chk("rd_idle_ready", a_ready, 3'b000);
        chk("rd_idle_busy", a_busy, 1'b0);
        chk("rd_hold", a_rdata, 32'hDEADBEEF);

        // Simultaneous ports 0 and 1 after reset, back-to-back grant
        pulse_reset();
        setp(0, 1'b0, 32'h100, 32'd0, 4'hF);
        setp(1, 1'b0, 32'h40, 32'd0, 4'hF);
        a_req = 3'b011;
        tick();
        chk("sim_gid0", a_gid, 2'd0);
        tick();
        tick();
        chk("sim_ready0", a_ready, 3'b001);
        chk("sim_data0", a_rdata, 32'hDEADBEEF);
        a_req = 3'b010;
        tick();
        chk("sim_nobubble", a_busy, 1'b1);
        chk("sim_gid1", a_gid, 2'd1);
        chk("sim_memaddr1", a_mem_addr, 32'h40);
        chk("sim_noready", a_ready, 3'b000);
        tick();
        tick();
        chk("sim_ready1", a_ready, 3'b010);
        chk("sim_data1", a_rdata, 32'hAABBCCDD);
        a_req = 3'b000;
        tick();

        // Port 1 partial write
        setp(1, 1'b1, 32'h40, 32'h11223344, 4'b0011);
        a_req = 3'b010;
        tick();
        chk("wr_gid", a_gid, 2'd1);
        chk("wr_we_cnt0", a_mem_we, 1'b0);
        tick();
        chk("wr_we_final", a_mem_we, 1'b1);
        chk("wr_be", a_mem_be, 4'b0011);
        chk("wr_wdata", a_mem_wdata, 32'h11223344);
        tick();
        chk("wr_we_done", a_mem_we, 1'b0);
        chk("wr_ready", a_ready, 3'b010);
        chk("wr_olddata", a_rdata, 32'hAABBCCDD);
        chk("wr_count", a_wr_cnt, 1);
        a_req = 3'b000;
        setp(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        setp(0, 1'b0, 32'h40, 32'd0, 4'hF);
        a_req = 3'b001;
        tick();
        tick();
        tick();
        chk("wr_readback", a_rdata, 32'hAABB3344);
        chk("wr_readback_rdy", a_ready, 3'b001);
        a_req = 3'b000;
        tick();
        chk("wr_count_after", a_wr_cnt, 1);

        // Three ports requesting continuously: grants 0,1,2,0,1,2
        pulse_reset();
        setp(0, 1'b0, 32'h100, 32'd0, 4'hF);
        setp(1, 1'b0, 32'h100, 32'd0, 4'hF);
        setp(2, 1'b0, 32'h100, 32'd0, 4'hF);
        a_req = 3'b111;
        exp_g = 2'd0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_gid", a_gid, exp_g);
            chk("rr_busy", a_busy, 1'b1);
            tick();
            tick();
            exp_r = 3'b001 << exp_g;
            chk("rr_ready", a_ready, exp_r);
            if (n == 5) a_req = 3'b000;
            else        a_req = 3'b111;
            exp_g = (exp_g == 2'd2) ? 2'd0 : exp_g + 2'd1;
        end
        tick();
        chk("rr_idle", a_busy, 1'b0);

        // Reset during the first cycle of a write
        setp(0, 1'b1, 32'h100, 32'h0, 4'hF);
        a_req = 3'b001;
        tick();
        chk("ab_busy_pre", a_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("ab_busy", a_busy, 1'b0);
        chk("ab_memwe", a_mem_we, 1'b0);
        chk("ab_memaddr", a_mem_addr, 32'd0);
        chk("ab_gid", a_gid, 2'd0);
        tick();
        tick();
        chk("ab_noready", a_ready, 3'b000);
        chk("ab_nowrite", a_wr_cnt, 1);
        rst = 1'b0;
        setp(0, 1'b0, 32'h100, 32'd0, 4'hF);
        setp(1, 1'b0, 32'h40, 32'd0, 4'hF);
        a_req = 3'b011;
        tick();
        chk("ab_first_gid", a_gid, 2'd0);
        tick();
        tick();
        chk("ab_ready", a_ready, 3'b001);
        chk("ab_unchanged", a_rdata, 32'hDEADBEEF);
        a_req = 3'b000;
        tick();
        tick();

        // LATENCY=5, single port; mid-access address change is ignored
        b_addr = 32'h200;
        b_req = 1'b1;
        tick();
        chk("l5_busy", b_busy, 1'b1);
        chk("l5_memaddr", b_mem_addr, 32'h200);
        b_addr = 32'h300;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("l5_addr_hold", b_mem_addr, 32'h200);
            chk("l5_noready", b_ready, 1'b0);
        end
        tick();
        chk("l5_ready", b_ready, 1'b1);
        chk("l5_data", b_rdata, 32'h0200C0DE);
        chk("l5_busy_done", b_busy, 1'b0);
        tick();
        chk("l5_idle_after_done", b_busy, 1'b0);
        chk("l5_ready_off", b_ready, 1'b0);
        tick();
        chk("l5_regrant", b_busy, 1'b1);
        chk("l5_regrant_addr", b_mem_addr, 32'h300);
        b_req = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        tick();
        chk("l5_ready2", b_ready, 1'b1);
        chk("l5_data2", b_rdata, 32'h0300C0DE);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
